// File: rtl/seq_alu.sv
// seq_alu: handshaked multi-cycle ALU on WIDTH-bit unsigned operands.
// Functions: AND/OR/XOR/ADD/SUB in one cycle; MUL/DIV/REM iterate one bit per
// cycle (shift-add multiply, restoring divide) when SEQ_ALU_MULDIV_EN is
// defined. Without SEQ_ALU_MULDIV_EN those funcs behave as illegal (ans=0,
// ZF=1), DZ is tied low and the CALC state is never entered.
module seq_alu #(
   parameter int WIDTH = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [3:0]       func,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ans,
   output logic             ZF,
   output logic             DZ
);

   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] ans_q, ans_d;
   logic             zf_q, zf_d;
   logic [WIDTH-1:0] simp_ans;

`ifdef SEQ_ALU_MULDIV_EN
   localparam int CW = $clog2(WIDTH + 1);

   logic [CW-1:0]    cnt_q, cnt_d;
   // a: multiplicand (MUL) or dividend shifting into quotient (DIV/REM)
   // b: multiplier shifting right (MUL) or divisor (DIV/REM)
   // acc: product accumulator (MUL) or partial remainder (DIV/REM)
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
   logic             is_mul_q, is_mul_d, is_rem_q, is_rem_d;
   logic             dz_q, dz_d;
   logic             simp_dz, go_calc;
   logic [WIDTH:0]   div_sh, div_diff;
   logic             div_ge;
   logic [WIDTH-1:0] it_a, it_b, it_acc, it_res;
`endif

   // Single-cycle results straight from the input operands; also decides
   // whether the accepted op needs the iterative engine.
   always_comb begin
      simp_ans = '0;
`ifdef SEQ_ALU_MULDIV_EN
      simp_dz  = 1'b0;
      go_calc  = 1'b0;
`endif
      case (func)
         4'b0000: simp_ans = in1 & in2;
         4'b0001: simp_ans = in1 | in2;
         4'b0010: simp_ans = in1 ^ in2;
         4'b0011: simp_ans = in1 + in2;
         4'b0100: simp_ans = in1 - in2;
`ifdef SEQ_ALU_MULDIV_EN
         4'b0101: go_calc = 1'b1;
         4'b0110: begin
            if (in2 == '0) begin
               simp_ans = '1;
               simp_dz  = 1'b1;
            end else begin
               go_calc = 1'b1;
            end
         end
         4'b0111: begin
            if (in2 == '0) begin
               simp_ans = in1;
               simp_dz  = 1'b1;
            end else begin
               go_calc = 1'b1;
            end
         end
`endif
         default: simp_ans = '0;
      endcase
   end

`ifdef SEQ_ALU_MULDIV_EN
   // One iteration of shift-add multiply or restoring divide.
   always_comb begin
      div_sh   = {acc_q, a_q[WIDTH-1]};
      div_diff = div_sh - {1'b0, b_q};
      // No borrow out of the top bit means the trial subtraction fits.
      div_ge   = ~div_diff[WIDTH];
      if (is_mul_q) begin
         it_acc = acc_q + (b_q[0] ? a_q : '0);
         it_a   = a_q << 1;
         it_b   = b_q >> 1;
         it_res = it_acc;
      end else begin
         it_acc = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
         it_a   = {a_q[WIDTH-2:0], div_ge};
         it_b   = b_q;
         it_res = is_rem_q ? it_acc : it_a;
      end
   end
`endif

   // Control FSM next-state and result capture.
   always_comb begin
      state_d  = state_q;
      ans_d    = ans_q;
      zf_d     = zf_q;
`ifdef SEQ_ALU_MULDIV_EN
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      is_mul_d = is_mul_q;
      is_rem_d = is_rem_q;
      dz_d     = dz_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
`ifdef SEQ_ALU_MULDIV_EN
               if (go_calc) begin
                  a_d      = in1;
                  b_d      = in2;
                  acc_d    = '0;
                  cnt_d    = CW'(WIDTH);
                  is_mul_d = (func == 4'b0101);
                  is_rem_d = (func == 4'b0111);
                  state_d  = CALC;
               end else begin
                  ans_d   = simp_ans;
                  zf_d    = (simp_ans == '0);
                  dz_d    = simp_dz;
                  state_d = DONE;
               end
`else
               ans_d   = simp_ans;
               zf_d    = (simp_ans == '0);
               state_d = DONE;
`endif
            end
         end
`ifdef SEQ_ALU_MULDIV_EN
         CALC: begin
            a_d   = it_a;
            b_d   = it_b;
            acc_d = it_acc;
            cnt_d = cnt_q - CW'(1);
            // Last iteration lands its result directly in the output regs.
            if (cnt_q == CW'(1)) begin
               ans_d   = it_res;
               zf_d    = (it_res == '0);
               dz_d    = 1'b0;
               state_d = DONE;
            end
         end
`endif
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ans_q   <= '0;
         zf_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ans_q   <= ans_d;
         zf_q    <= zf_d;
      end
   end

`ifdef SEQ_ALU_MULDIV_EN
   // Iterative engine registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         is_mul_q <= 1'b0;
         is_rem_q <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         is_mul_q <= is_mul_d;
         is_rem_q <= is_rem_d;
         dz_q     <= dz_d;
      end
   end
   assign DZ = dz_q;
`else
   assign DZ = 1'b0;
`endif

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign ans       = ans_q;
   assign ZF        = zf_q;

endmodule
